// File: rtl/ks_adder_pipe_if.sv
// Operand/result bundle for ks_adder_pipe: request side (in_*) and result side (out_*).
// Latency: none, this is wiring only.
// Backpressure: in_ready / out_ready carry the valid-ready handshakes on each side.
// Ports (by modport):
//   slave  - the adder: consumes in_valid/in_a/in_b/in_cin/in_sub/in_sat/in_tag and out_ready,
//            drives in_ready and out_valid/out_sum/out_cout/out_ovf/out_tag.
//   master - the feeding logic: the mirror image of slave.
interface ks_adder_pipe_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             in_sat;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, in_sat, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, in_sat, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );
endinterface

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone add/subtract with carry-in, carry-out, signed overflow and a sideband tag.
// Latency: ceil(clog2(WIDTH)/LPS) + 2 cycles from accepted beat to out_valid.
// Backpressure: a held result (out_valid & ~out_ready) freezes every stage and drops in_ready.
// Ports: clk, rst (synchronous, active-high); bus (ks_adder_pipe_if.slave) carries
//   in_valid/in_ready/in_a/in_b/in_cin/in_sub/in_sat/in_tag and
//   out_valid/out_ready/out_sum/out_cout/out_ovf/out_tag.
// Build option: define KS_SATURATE_EN to clamp out_sum on signed overflow when in_sat=1.
module ks_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int LPS   = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  ks_adder_pipe_if.slave   bus
);
  localparam int L  = $clog2(WIDTH);
  localparam int NS = (L + LPS - 1) / LPS;

  // Index 0 is the bitwise stage; index s>0 holds the state after prefix group s.
  logic [WIDTH-1:0] r_g   [0:NS];
  logic [WIDTH-1:0] r_p   [0:NS];
  logic [WIDTH-1:0] r_pb  [0:NS];
  logic [TAG_W-1:0] r_tag [0:NS];
  logic [NS:0]      r_c0;
  logic [NS:0]      r_vld;
`ifdef KS_SATURATE_EN
  logic [NS:0]      r_sat;
`else
  logic             sat_unused;
  assign sat_unused = bus.in_sat;
`endif

  logic             stall;
  logic [WIDTH-1:0] b_eff;

  assign stall        = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall & ~rst;
  assign b_eff        = bus.in_sub ? ~bus.in_b : bus.in_b;

  // Carry-in folded into bit 0's generate, so every prefix G[i] becomes the carry out of bit i.
  logic [WIDTH-1:0] fold_g;
  assign fold_g = {r_g[0][WIDTH-1:1], r_g[0][0] | (r_p[0][0] & r_c0[0])};

  logic [WIDTH-1:0] src_g [0:L-1];
  logic [WIDTH-1:0] src_p [0:L-1];
  logic [WIDTH-1:0] lvl_g [0:L-1];
  logic [WIDTH-1:0] lvl_p [0:L-1];

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int D = 1 << k;
    if (k == 0) begin : g_first
      assign src_g[k] = fold_g;
      assign src_p[k] = r_p[0];
    end else if (k % LPS == 0) begin : g_from_reg
      assign src_g[k] = r_g[k / LPS];
      assign src_p[k] = r_p[k / LPS];
    end else begin : g_chain
      assign src_g[k] = lvl_g[k-1];
      assign src_p[k] = lvl_p[k-1];
    end
    // Bits below distance D have no partner and pass through; shifted-in zeros/ones preserve that.
    assign lvl_g[k] = src_g[k] | (src_p[k] & (src_g[k] << D));
    assign lvl_p[k] = src_p[k] & ~((~src_p[k]) << D);
  end

  logic [WIDTH-1:0] stg_g [1:NS];
  logic [WIDTH-1:0] stg_p [1:NS];

  for (genvar s = 1; s <= NS; s++) begin : g_stg
    localparam int LAST = ((s * LPS < L) ? s * LPS : L) - 1;
    assign stg_g[s] = lvl_g[LAST];
    assign stg_p[s] = lvl_p[LAST];
  end

  // Group propagate is no longer needed once all prefix levels are done.
  logic p_unused;
  assign p_unused = ^r_p[NS];

  logic [WIDTH-1:0] g_fin;
  logic [WIDTH-1:0] sum_fin;
  logic             cout_fin;
  logic             ovf_fin;

  assign g_fin    = r_g[NS];
  assign cout_fin = g_fin[WIDTH-1];
  assign ovf_fin  = g_fin[WIDTH-1] ^ g_fin[WIDTH-2];

  always_comb begin
    sum_fin = r_pb[NS] ^ {g_fin[WIDTH-2:0], r_c0[NS]};
`ifdef KS_SATURATE_EN
    // Wrapped MSB set means the true result was positive: clamp to max positive, else min negative.
    if (r_sat[NS] && ovf_fin) begin
      sum_fin = {~sum_fin[WIDTH-1], {(WIDTH-1){sum_fin[WIDTH-1]}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_c0  <= '0;
`ifdef KS_SATURATE_EN
      r_sat <= '0;
`endif
      for (int s = 0; s <= NS; s++) begin
        r_g[s]   <= '0;
        r_p[s]   <= '0;
        r_pb[s]  <= '0;
        r_tag[s] <= '0;
      end
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_cout  <= 1'b0;
      bus.out_ovf   <= 1'b0;
      bus.out_tag   <= '0;
    end else if (!stall) begin
      // in_ready is high whenever this branch runs, so in_valid alone marks an accepted beat.
      r_vld[0] <= bus.in_valid;
      r_g[0]   <= bus.in_a & b_eff;
      r_p[0]   <= bus.in_a ^ b_eff;
      r_pb[0]  <= bus.in_a ^ b_eff;
      r_c0[0]  <= bus.in_sub | bus.in_cin;
      r_tag[0] <= bus.in_tag;
`ifdef KS_SATURATE_EN
      r_sat[0] <= bus.in_sat;
`endif
      for (int s = 1; s <= NS; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_g[s]   <= stg_g[s];
        r_p[s]   <= stg_p[s];
        r_pb[s]  <= r_pb[s-1];
        r_c0[s]  <= r_c0[s-1];
        r_tag[s] <= r_tag[s-1];
`ifdef KS_SATURATE_EN
        r_sat[s] <= r_sat[s-1];
`endif
      end
      bus.out_valid <= r_vld[NS];
      bus.out_sum   <= sum_fin;
      bus.out_cout  <= cout_fin;
      bus.out_ovf   <= ovf_fin;
      bus.out_tag   <= r_tag[NS];
    end
  end
endmodule
